// File: rtl/mem_arbiter_if.sv
// ============================================================================
// mem_arbiter_if : requester and RAM-side bus of the two-port memory arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

interface mem_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              gnt0;
  logic              rvalid0;
  logic [DATA_W-1:0] rdata0;

  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              gnt1;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata1;

  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic              ram_we;
  logic [DATA_W-1:0] ram_dout;
  logic              busy;

  // Requesters and the RAM instance together form the environment side.
  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output ram_dout,
    input  gnt0, rvalid0, rdata0,
    input  gnt1, rvalid1, rdata1,
    input  ram_addr, ram_din, ram_we, busy
  );

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  ram_dout,
    output gnt0, rvalid0, rdata0,
    output gnt1, rvalid1, rdata1,
    output ram_addr, ram_din, ram_we, busy
  );
endinterface

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// mem_arbiter : round-robin two-port arbiter for a single-port word RAM
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 2   // legal range 1..7
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_t;

  localparam logic [2:0] c_CNT_LOAD = 3'(RD_LAT - 1);

  state_t            r_state,   w_state_nxt;
  logic [2:0]        r_cnt,     w_cnt_nxt;
  logic              r_rd_port, w_rd_port_nxt;
  logic              r_last,    w_last_nxt;
  logic [ADDR_W-1:0] r_addr,    w_addr_nxt;
  logic [DATA_W-1:0] r_din,     w_din_nxt;

  logic              w_rd_done;
  logic              w_can_grant;
  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_grant;
  logic              w_gnt_we;
  logic [ADDR_W-1:0] w_gnt_addr;
  logic [DATA_W-1:0] w_gnt_din;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= 3'd0;
      r_rd_port <= 1'b0;
      r_last    <= 1'b1;
      r_addr    <= '0;
      r_din     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_rd_port <= w_rd_port_nxt;
      r_last    <= w_last_nxt;
      r_addr    <= w_addr_nxt;
      r_din     <= w_din_nxt;
    end
  end

  always_comb begin
    w_rd_done   = (r_state == RD_WAIT) && (r_cnt == 3'd0);
    // Reset is folded in so every output reads zero while rst is high.
    w_can_grant = !rst && ((r_state == IDLE) || w_rd_done);

    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (w_can_grant) begin
      if (bus.req0 && bus.req1) begin
        w_gnt0 = r_last;
        w_gnt1 = !r_last;
      end else begin
        w_gnt0 = bus.req0;
        w_gnt1 = bus.req1;
      end
    end

    w_grant    = w_gnt0 | w_gnt1;
    w_gnt_we   = w_gnt1 ? bus.we1    : bus.we0;
    w_gnt_addr = w_gnt1 ? bus.addr1  : bus.addr0;
    w_gnt_din  = w_gnt1 ? bus.wdata1 : bus.wdata0;

    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_rd_port_nxt = r_rd_port;
    w_last_nxt    = r_last;
    w_addr_nxt    = r_addr;
    w_din_nxt     = r_din;

    if (r_state == RD_WAIT) begin
      if (r_cnt != 3'd0) begin
        w_cnt_nxt = r_cnt - 3'd1;
      end else begin
        w_state_nxt = IDLE;
      end
    end

    // A read granted on the final wait cycle re-enters RD_WAIT seamlessly.
    if (w_grant) begin
      w_last_nxt = w_gnt1;
      w_addr_nxt = w_gnt_addr;
      w_din_nxt  = w_gnt_din;
      if (!w_gnt_we) begin
        w_state_nxt   = RD_WAIT;
        w_cnt_nxt     = c_CNT_LOAD;
        w_rd_port_nxt = w_gnt1;
      end
    end
  end

  assign bus.gnt0     = w_gnt0;
  assign bus.gnt1     = w_gnt1;
  assign bus.ram_we   = w_grant & w_gnt_we;
  assign bus.ram_addr = w_grant ? w_gnt_addr : r_addr;
  assign bus.ram_din  = w_grant ? w_gnt_din  : r_din;
  assign bus.busy     = (r_state == RD_WAIT);

  assign bus.rvalid0  = w_rd_done & !r_rd_port;
  assign bus.rvalid1  = w_rd_done &  r_rd_port;
  assign bus.rdata0   = bus.rvalid0 ? bus.ram_dout : '0;
  assign bus.rdata1   = bus.rvalid1 ? bus.ram_dout : '0;

endmodule

`default_nettype wire
